// File: rtl/demux1_4_3_reg_if.sv
// ----------------------------------------------------------------------------
// demux1_4_3_reg_if
//
// Purpose: bundles the producer stream and the four consumer channels of the
// registered 1-to-4 demultiplexer into one interface.
//
// Handshake semantics (valid/ready, both sides):
//   A transfer happens on a rising clk edge exactly when valid and ready are
//   both 1 in the cycle before it. The offering side holds its payload stable
//   while valid=1 and ready=0. Ready never depends on the same side's valid.
//
// Signals:
//   in_data   [W]        producer data
//   in_sel    [2]        destination channel index 0..3
//   in_valid             producer offers in_data/in_sel
//   in_ready             demux accepts the offer this cycle
//   o_data    [4*W]      channel k data on [k*W +: W]
//   o_valid   [4]        bit k: channel k holds valid data
//   o_ready   [4]        bit k: consumer k takes data this cycle
//   cnt_flat  [4*CNT_W]  channel k accept count (only with DEMUX_CNT_EN)
//
// Modports:
//   master - producer and consumers (drives in_*, o_ready)
//   slave  - the demultiplexer
//
// Optional feature macro: DEMUX_CNT_EN adds cnt_flat.
// ----------------------------------------------------------------------------
interface demux1_4_3_reg_if #(
  parameter int W     = 3,
  parameter int CNT_W = 8
);
  logic [W-1:0]       in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*W-1:0]     o_data;
  logic [3:0]         o_valid;
  logic [3:0]         o_ready;
`ifdef DEMUX_CNT_EN
  logic [4*CNT_W-1:0] cnt_flat;
`endif

`ifdef DEMUX_CNT_EN
  modport master (
    output in_data, in_sel, in_valid, o_ready,
    input  in_ready, o_data, o_valid, cnt_flat
  );

  modport slave (
    input  in_data, in_sel, in_valid, o_ready,
    output in_ready, o_data, o_valid, cnt_flat
  );
`else
  modport master (
    output in_data, in_sel, in_valid, o_ready,
    input  in_ready, o_data, o_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, o_ready,
    output in_ready, o_data, o_valid
  );
`endif
endinterface

// File: rtl/demux1_4_3_reg.sv
// ----------------------------------------------------------------------------
// demux1_4_3_reg
//
// Purpose: registered 1-to-4 demultiplexer. A single producer stream is
// steered by in_sel into one of four consumer channels, each with a 1-deep
// holding register. Channels stall independently; a full channel whose
// consumer is taking its data can be reloaded in the same cycle, so there is
// no bubble.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears valids, data and counters)
//   bus   demux1_4_3_reg_if.slave (see interface file for signal list and
//         the valid/ready contract)
//
// Channel state: each channel is a two-state machine (EMPTY/FULL). The
// state vector is exported directly as o_valid, so o_valid[k]==1 means
// channel k is FULL.
//
// Optional feature macro: DEMUX_CNT_EN
//   Defined     : four CNT_W-bit wrapping accept counters on bus.cnt_flat.
//   Not defined : no counters; the datapath is identical.
// ----------------------------------------------------------------------------
module demux1_4_3_reg #(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux1_4_3_reg_if.slave       bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e      state_q [4];
  chan_state_e      state_d [4];
  logic [W-1:0]     data_q  [4];
  logic [W-1:0]     data_d  [4];

  logic             in_ready_w;
  logic             acc;
  logic [3:0]       take;
  logic [3:0]       load;

  // --------------------------------------------------------------------------
  // Handshake decode.
  // in_ready only looks at the addressed channel: it is free when empty or
  // when its consumer is draining it this cycle. in_valid is deliberately not
  // an input here so the producer never sees a ready that waits on its own
  // valid.
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready_w = 1'b0;
    acc        = 1'b0;
    take       = 4'b0000;
    load       = 4'b0000;

    in_ready_w = (state_q[bus.in_sel] == EMPTY) || bus.o_ready[bus.in_sel];
    acc        = bus.in_valid && in_ready_w;

    for (int k = 0; k < 4; k++) begin
      take[k] = (state_q[k] == FULL) && bus.o_ready[k];
      load[k] = acc && (bus.in_sel == 2'(k));
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel next state and next data.
  // A load wins over a take: a FULL channel that is taken and reloaded in the
  // same cycle stays FULL with the new data. A take alone empties the channel
  // but leaves the data register untouched.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];

      case (state_q[k])
        EMPTY: begin
          if (load[k]) begin
            state_d[k] = FULL;
          end
        end
        FULL: begin
          if (take[k] && !load[k]) begin
            state_d[k] = EMPTY;
          end
        end
        default: begin
          state_d[k] = EMPTY;
        end
      endcase

      if (load[k]) begin
        data_d[k] = bus.in_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and data registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs.
  // --------------------------------------------------------------------------
  assign bus.in_ready = in_ready_w;

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign bus.o_valid[g]        = (state_q[g] == FULL);
    assign bus.o_data[g*W +: W]  = data_q[g];
  end

`ifdef DEMUX_CNT_EN
  // --------------------------------------------------------------------------
  // Accept counters: counter k counts loads into channel k and wraps
  // naturally at 2^CNT_W.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (load[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cnt_out
    assign bus.cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_demux1_4_3_reg.sv
// ----------------------------------------------------------------------------
// tb_demux1_4_3_reg
//
// Self-checking bench for demux1_4_3_reg. The reference model treats every
// channel as a FIFO of capacity one (a queue per channel): an offer is
// accepted when the addressed queue is empty or its head leaves this cycle,
// a take pops the head, an accept pushes to the tail. Channel data outputs
// track the most recently loaded value per channel.
// Works with and without DEMUX_CNT_EN.
// ----------------------------------------------------------------------------
module tb_demux1_4_3_reg;

  localparam int W     = 3;
  localparam int CNT_W = 8;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  demux1_4_3_reg_if #(.W(W), .CNT_W(CNT_W)) bus_if ();

  demux1_4_3_reg #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // --------------------------------------------------------------------------
  // Scoreboard / reference model
  // --------------------------------------------------------------------------
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] last_data [4];
  int           exp_cnt [4];

  int           n_checks = 0;
  int           n_errors = 0;
  logic         last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      last_data[k] = '0;
      exp_cnt[k]   = 0;
    end
  endfunction

  // Compare every visible output against the model's current view.
  task automatic check_outputs();
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("o_valid[%0d]", k), 32'(bus_if.o_valid[k]),
               32'(exp_q[k].size() != 0));
      check_eq($sformatf("o_data[%0d]", k), 32'(bus_if.o_data[k*W +: W]),
               32'(last_data[k]));
`ifdef DEMUX_CNT_EN
      check_eq($sformatf("cnt[%0d]", k), 32'(bus_if.cnt_flat[k*CNT_W +: CNT_W]),
               32'(exp_cnt[k]));
`endif
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic drive_idle();
    bus_if.in_valid = 1'b0;
    bus_if.in_sel   = 2'd0;
    bus_if.in_data  = '0;
    bus_if.o_ready  = 4'b0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive at the falling edge, check just after, then let
  // the rising edge happen and advance the model.
  task automatic step(input logic v, input logic [1:0] s,
                      input logic [W-1:0] d, input logic [3:0] r);
    logic       exp_rdy;
    logic       acc;
    logic [3:0] takes;
    @(negedge clk);
    bus_if.in_valid = v;
    bus_if.in_sel   = s;
    bus_if.in_data  = d;
    bus_if.o_ready  = r;
    #1;
    exp_rdy = (exp_q[s].size() == 0) || r[s];
    check_eq("in_ready", 32'(bus_if.in_ready), 32'(exp_rdy));
    check_outputs();
    for (int k = 0; k < 4; k++) begin
      takes[k] = (exp_q[k].size() != 0) && r[k];
      if (takes[k]) begin
        check_eq($sformatf("take_data[%0d]", k), 32'(bus_if.o_data[k*W +: W]),
                 32'(exp_q[k][0]));
      end
    end
    acc      = v && exp_rdy;
    last_acc = acc;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (takes[k]) void'(exp_q[k].pop_front());
    end
    if (acc) begin
      exp_q[s].push_back(d);
      last_data[s] = d;
      exp_cnt[s]   = (exp_cnt[s] + 1) % (1 << CNT_W);
    end
  endtask

  // Observe outputs between edges without driving a new cycle.
  task automatic peek_at_negedge();
    @(negedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : main
    logic       have_offer;
    logic       v;
    logic [1:0] s;
    logic [W-1:0] d;
    logic [3:0] r;

    drive_idle();
    model_clear();
    rst = 1'b1;
    #2;
    check_eq("rst_o_valid", 32'(bus_if.o_valid), 32'h0);
    check_eq("rst_o_data", 32'(bus_if.o_data), 32'h0);
    do_reset();
    check_outputs();

    // Single load to channel 2, then channel 2 blocks its input.
    step(1'b1, 2'd2, 3'b101, 4'b0000);
    peek_at_negedge();
    check_eq("load2_valid", 32'(bus_if.o_valid), 32'h4);
    check_eq("load2_data", 32'(bus_if.o_data), 32'(12'b000_101_000_000));
    step(1'b0, 2'd2, 3'd0, 4'b0000);

    // Pass-through on channel 1: full, being taken, reloaded with no gap.
    step(1'b1, 2'd1, 3'd3, 4'b0000);
    step(1'b1, 2'd1, 3'd6, 4'b0010);
    peek_at_negedge();
    check_eq("pass_valid1", 32'(bus_if.o_valid[1]), 32'h1);
    check_eq("pass_data1", 32'(bus_if.o_data[1*W +: W]), 32'h6);

    // Channel 3 full and stalled for 5 cycles, then released.
    step(1'b1, 2'd3, 3'd7, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'd3, 3'd2, 4'b0000);
      check_eq("stall_no_acc", 32'(last_acc), 32'h0);
    end
    step(1'b1, 2'd3, 3'd2, 4'b1000);
    check_eq("stall_release_acc", 32'(last_acc), 32'h1);

    // Drain, fill all four with 1..4, then drain all in one cycle.
    step(1'b0, 2'd0, 3'd0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'(i), 3'(i + 1), 4'b0000);
    end
    step(1'b0, 2'd0, 3'd0, 4'b1111);
    peek_at_negedge();
    check_eq("drain_all_valid", 32'(bus_if.o_valid), 32'h0);
    check_eq("drain_all_data", 32'(bus_if.o_data), 32'(12'b100_011_010_001));

    // Asynchronous reset between edges with channels 0 and 2 full.
    step(1'b1, 2'd0, 3'd5, 4'b0000);
    step(1'b1, 2'd2, 3'd6, 4'b0000);
    peek_at_negedge();
    check_eq("pre_async_valid", 32'(bus_if.o_valid), 32'h5);
    drive_idle();
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(bus_if.o_valid), 32'h0);
    check_eq("async_rst_data", 32'(bus_if.o_data), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_outputs();

    // Randomized traffic; an unaccepted offer is held stable.
    have_offer = 1'b0;
    v = 1'b0; s = 2'd0; d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!have_offer) begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = W'($urandom_range(0, (1 << W) - 1));
      end
      r = 4'($urandom_range(0, 15));
      step(v, s, d, r);
      have_offer = v && !last_acc;
    end
    step(1'b0, 2'd0, 3'd0, 4'b0000);

`ifdef DEMUX_CNT_EN
    // Counter wrap: 257 accepts to channel 0.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 2'd0, 3'(i), 4'b0001);
    end
    peek_at_negedge();
    check_eq("cnt0_wrap", 32'(bus_if.cnt_flat[0 +: CNT_W]), 32'h1);
    check_eq("cnt123_zero", 32'(bus_if.cnt_flat[4*CNT_W-1:CNT_W]), 32'h0);
`endif

    peek_at_negedge();
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux1_4_3_reg.md
Name: demux1_4_3_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the 4:1 selection muxes in the single-cycle CPU datapath.
- One producer stream is steered by a 2-bit select into one of four independent consumer channels.
- Each consumer channel has a 1-deep holding register.
- Used to fan a decoded 3-bit field (e.g. ALU op / writeback tag) out to four consumers that may stall independently.

Parameters:
- W, 3, data width of the input stream and of each output channel.
- CNT_W, 8, width of per-channel transfer counters (used only when DEMUX_CNT_EN is defined).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_data  input  W  producer data.
- in_sel  input  2  destination channel index, 0..3.
- in_valid  input  1  producer offers in_data/in_sel.
- in_ready  output  1  block accepts the offer this cycle.
- o_data  output  4*W  channel k data on bits [k*W +: W].
- o_valid  output  4  bit k: channel k holds valid data.
- o_ready  input  4  bit k: consumer k takes data this cycle.
- cnt_flat  output  4*CNT_W  channel k accept count on [k*CNT_W +: CNT_W]; present only with DEMUX_CNT_EN.

Behaviour:
- Reset is asynchronous, active-high, one clock.
  - On rst: o_valid=4'b0000, o_data=0, all counters=0.
  - Reset asserted mid-transfer discards held data; no partial state survives.
- Per-channel "take" condition: take[k] = o_valid[k] & o_ready[k].
- in_ready = ~o_valid[in_sel] | o_ready[in_sel].
  - Purely combinational from in_sel and the channel state; must not depend on in_valid.
  - A full channel may accept new data in the same cycle its consumer takes the old data (pass-through, no bubble).
- Accept condition: acc = in_valid & in_ready.
- On acc at edge N:
  - channel in_sel: o_data <= in_data and o_valid <= 1, visible after edge N.
  - Latency from input to output is 1 cycle.
- Channel k with take[k] and no acc to k: o_valid[k] <= 0; o_data[k] holds its last value.
- Channel k with take[k] and acc to k in the same cycle: o_valid[k] stays 1 and o_data[k] is replaced.
- Channels not addressed by in_sel are unaffected, apart from their own take.
- At most one channel loads per cycle; any number of channels may drain in the same cycle.
- Blocking:
  - If in_valid=1, o_valid[in_sel]=1 and o_ready[in_sel]=0, then in_ready=0.
  - The producer must hold in_data/in_sel stable until accepted.
  - The block does not reorder or skip to other channels.
- o_ready[k] while o_valid[k]=0 has no effect.
- No internal FSM beyond the four 1-bit channel-valid flags. Each flag has two states, EMPTY and FULL:
  - EMPTY -> FULL on acc to k.
  - FULL -> EMPTY on take without acc to k.
  - FULL -> FULL on take with acc to k, or on no take.

Optional Feature:
- DEMUX_CNT_EN
- Defined:
  - Four CNT_W-bit counters; counter k increments on every acc with in_sel=k.
  - Counters wrap modulo 2^CNT_W (255 -> 0).
  - Counters reset to 0; exposed on cnt_flat.
- Not defined: no counters and no cnt_flat port; datapath behaviour is identical.

Test Plan:
- Reset, then in_sel=2, in_data=3'b101, in_valid=1 for 1 cycle, o_ready=0 -> after the edge o_valid=4'b0100 and channel 2 data=5; other channels 0; in_ready for sel 2 then 0.
- Channel 1 full, o_ready[1]=1, in_sel=1, in_data=6, in_valid=1 -> in_ready=1; after the edge o_valid[1]=1 and channel 1 data=6 (pass-through, no empty cycle).
- Channel 3 full and stalled (o_ready[3]=0), in_sel=3 held for 5 cycles -> in_ready=0 throughout; then o_ready[3]=1 -> accepted on that edge.
- Fill all four channels on consecutive cycles with data 1,2,3,4, then o_ready=4'b1111 for 1 cycle -> o_valid=4'b0000 and o_data unchanged.
- Assert rst asynchronously between edges while channels 0 and 2 are full -> o_valid=0 immediately, before the next clk edge.
- With DEMUX_CNT_EN: 257 accepts to channel 0 -> cnt0=1 (wrapped); cnt1..cnt3=0.
